// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, state and flag types shared by the multi-cycle ALU
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADIC = 4'd1,
        OP_SUB  = 4'd2,
        OP_OU   = 4'd3,
        OP_E    = 4'd4,
        OP_NAO  = 4'd5,
        OP_XOU  = 4'd6,
        OP_DLE  = 4'd7,
        OP_DLD  = 4'd8,
        OP_DAE  = 4'd9,
        OP_DAD  = 4'd10,
        OP_MUL  = 4'd11,
        OP_DIV  = 4'd12,
        OP_ADC  = 4'd13,
        OP_SBB  = 4'd14
    } opcode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic b;
        logic v;
    } flags_t;

    function automatic logic is_multi_cycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_comb_w.sv
// rtl/alu_comb_w.sv - combinational datapath for every single-cycle ALU operation
module alu_comb_w
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] y_o,
    output flags_t           flags_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] y;
    flags_t           f;
    logic             known;

    always_comb begin
        y     = '0;
        f     = '0;
        sum   = '0;
        known = 1'b1;
        case (op_i)
            OP_ADIC, OP_ADC: begin
                sum = {1'b0, a_i} + {1'b0, b_i}
                    + {{WIDTH{1'b0}}, (op_i == OP_ADC) & cin_i};
                y   = sum[WIDTH-1:0];
                f.c = sum[WIDTH];
                f.v = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (y[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                // The extra top bit wraps to 1 exactly when the difference goes negative.
                sum = {1'b0, a_i} - {1'b0, b_i}
                    - {{WIDTH{1'b0}}, (op_i == OP_SBB) & cin_i};
                y   = sum[WIDTH-1:0];
                f.b = sum[WIDTH];
                f.v = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (y[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_OU:  y = a_i | b_i;
            OP_E:   y = a_i & b_i;
            OP_NAO: y = ~a_i;
            OP_XOU: y = a_i ^ b_i;
            OP_DLE: begin
                y   = {a_i[WIDTH-2:0], cin_i};
                f.c = a_i[WIDTH-1];
            end
            OP_DAE: begin
                y   = {a_i[WIDTH-2:0], 1'b0};
                f.c = a_i[WIDTH-1];
            end
            OP_DLD: begin
                y   = {cin_i, a_i[WIDTH-1:1]};
                f.c = a_i[0];
            end
            OP_DAD: begin
                y   = {1'b0, a_i[WIDTH-1:1]};
                f.c = a_i[0];
            end
            default: known = 1'b0;
        endcase
        if (known) begin
            f.z = ~|y;
            f.n = y[WIDTH-1];
        end else begin
            f.z = 1'b1;
        end
    end

    assign y_o     = y;
    assign flags_o = f;

endmodule

// File: rtl/alu_multiciclo.sv
// rtl/alu_multiciclo.sv - registered ALU with single-cycle ops and iterative MUL/DIV
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       operacao,
    input  logic [WIDTH-1:0] operA,
    input  logic [WIDTH-1:0] operB,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             B,
    output logic             V
);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] m_q;
    logic             is_div_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    flags_t           flags_q;

    logic [WIDTH-1:0] comb_y;
    flags_t           comb_flags;

    alu_comb_w #(
        .WIDTH(WIDTH)
    ) u_comb (
        .op_i   (operacao),
        .a_i    (operA),
        .b_i    (operB),
        .cin_i  (Cin),
        .y_o    (comb_y),
        .flags_o(comb_flags)
    );

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic             prod_hi_nz;
    flags_t           fin_flags;

    // hi_q/lo_q hold {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ok    = div_shift >= {1'b0, m_q};
        div_diff  = div_shift[WIDTH-1:0] - m_q;
        if (is_div_q) begin
            hi_d = div_ok ? div_diff : div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ok};
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end

        prod_hi_nz = |hi_d;
        fin_flags  = '0;
        if (is_div_q) begin
            fin_flags.n = lo_d[WIDTH-1];
            fin_flags.z = ~|lo_d;
            fin_flags.v = ~|m_q;
        end else begin
            fin_flags.n = hi_d[WIDTH-1];
            fin_flags.z = ~prod_hi_nz & ~|lo_d;
            fin_flags.c = prod_hi_nz;
            fin_flags.v = prod_hi_nz;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            m_q         <= '0;
            is_div_q    <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (is_multi_cycle(operacao)) begin
                            is_div_q <= (operacao == OP_DIV);
                            hi_q     <= '0;
                            lo_q     <= (operacao == OP_DIV) ? operA : operB;
                            m_q      <= (operacao == OP_DIV) ? operB : operA;
                            cnt_q    <= CNT_W'(WIDTH);
                            state_q  <= RUN;
                        end else begin
                            result_q    <= comb_y;
                            result_hi_q <= '0;
                            flags_q     <= comb_flags;
                            done_q      <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= IDLE;
                        result_q    <= lo_d;
                        result_hi_q <= hi_d;
                        flags_q     <= fin_flags;
                        done_q      <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign N         = flags_q.n;
    assign Z         = flags_q.z;
    assign C         = flags_q.c;
    assign B         = flags_q.b;
    assign V         = flags_q.v;

endmodule
